// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF requester, DM requester and the
// single memory port.
//   slave  : arbiter view (takes requests, drives grants/responses and memory)
//   master : client/memory-model view (drives requests and memory read data)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           mem_req, mem_we, mem_ctrl, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch and data-memory stages of the RV32I pipeline.
// Sequence per access: grant (IDLE or response cycle) -> ISSUE (mem_req)
// -> WAIT (MEM_LAT-1 cycles) -> response cycle (rvalid, re-arbitrate).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (IF/DM request/response, memory port,
//            stall outputs)
// Parameters: MEM_LAT (>=1) memory read latency, STARVE_MAX (>=1) IF losses
// before IF is forced to win a tie.
// Optional: define MISALIGN_TRAP_EN to trap misaligned DM accesses with
// dm_err instead of sending them to memory.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  state_t        state, state_nx;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_dm;
  mem_cmd_t      cmd;

  logic rsp, arb, if_elig, dm_elig, if_force, if_win, dm_win, dm_mis;

  always_comb begin
    rsp      = (state == WAIT) && (lat_cnt == '0);
    // gated by rst_n so no grant leaks out while reset is held
    arb      = rst_n && ((state == IDLE) || rsp);
    // the owner of the completing access still has req high; skip it
    if_elig  = bus.if_req && !(rsp && !owner_dm);
    dm_elig  = bus.dm_req && !(rsp && owner_dm);
    if_force = (starve_cnt == SW'(STARVE_MAX));
    if_win   = arb && if_elig && (!dm_elig || if_force);
    dm_win   = arb && dm_elig && !if_win;
`ifdef MISALIGN_TRAP_EN
    dm_mis   = ((bus.dm_ctrl[1:0] == 2'b01) && bus.dm_addr[0]) ||
               ((bus.dm_ctrl == 3'b010) && (bus.dm_addr[1:0] != 2'b00));
`else
    dm_mis   = 1'b0;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, WAIT: if (arb) begin
        if (dm_win)      state_nx = dm_mis ? ERR : ISSUE;
        else if (if_win) state_nx = ISSUE;
        else             state_nx = IDLE;
      end
      ISSUE:   state_nx = WAIT;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    bus.if_gnt    = if_win;
    bus.dm_gnt    = dm_win;
    bus.if_rvalid = rsp && !owner_dm;
    bus.if_rdata  = (rsp && !owner_dm) ? bus.mem_rdata : 32'h0;
    bus.dm_rvalid = (rsp && owner_dm) || (state == ERR);
    bus.dm_rdata  = (rsp && owner_dm && !cmd.we) ? bus.mem_rdata : 32'h0;
    bus.dm_err    = (state == ERR);
    bus.mem_req   = (state == ISSUE);
    bus.mem_we    = cmd.we;
    bus.mem_ctrl  = cmd.ctrl;
    bus.mem_addr  = cmd.addr;
    bus.mem_wdata = cmd.wdata;
    bus.stall_if  = bus.if_req && !bus.if_rvalid;
    bus.stall_mem = bus.dm_req && !bus.dm_rvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      cmd        <= '0;
    end else begin
      state <= state_nx;

      if (state == ISSUE)                    lat_cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT && lat_cnt != 0) lat_cnt <= lat_cnt - CW'(1);

      // a loss counts only when IF was a live contender
      if (if_win)                                           starve_cnt <= '0;
      else if (dm_win && if_elig && !if_force)              starve_cnt <= starve_cnt + SW'(1);

      if (if_win) begin
        owner_dm <= 1'b0;
        cmd      <= '{we: 1'b0, ctrl: 3'b010, addr: bus.if_addr, wdata: 32'h0};
      end else if (dm_win) begin
        owner_dm <= 1'b1;
        // trapped accesses never reach memory, so leave mem_* untouched
        if (!dm_mis)
          cmd <= '{we: bus.dm_we, ctrl: bus.dm_ctrl, addr: bus.dm_addr, wdata: bus.dm_wdata};
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after posedge; outputs are sampled on negedge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic dm_set(input logic req, input logic we, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.dm_req   = req;
    bus.dm_we    = we;
    bus.dm_ctrl  = ctrl;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_rdata = '0;
    dm_set(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // reset state
    repeat (2) nxt();
    smp();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_gnt", {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.dm_err}, 5'b0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // lone fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.mem_rdata = 32'h00A00093;
    smp();
    chk("if_gnt_c0", bus.if_gnt, 1'b1);
    chk("stall_if_c0", bus.stall_if, 1'b1);
    chk("mem_req_c0", bus.mem_req, 1'b0);
    nxt(); smp();
    chk("mem_req_c1", bus.mem_req, 1'b1);
    chk("mem_addr_c1", bus.mem_addr, 32'h10);
    chk("mem_ctrl_c1", bus.mem_ctrl, 3'b010);
    chk("mem_we_c1", bus.mem_we, 1'b0);
    chk("stall_if_c1", bus.stall_if, 1'b1);
    nxt(); smp();
    chk("mem_req_c2", bus.mem_req, 1'b0);
    chk("if_rvalid_c2", bus.if_rvalid, 1'b0);
    chk("stall_if_c2", bus.stall_if, 1'b1);
    nxt(); smp();
    chk("if_rvalid_c3", bus.if_rvalid, 1'b1);
    chk("if_rdata_c3", bus.if_rdata, 32'h00A00093);
    chk("stall_if_c3", bus.stall_if, 1'b0);
    chk("if_regnt_c3", bus.if_gnt, 1'b0);
    nxt();
    bus.if_req = 1'b0;
    smp();
    chk("idle_c4", {bus.mem_req, bus.if_gnt, bus.if_rvalid}, 3'b0);
    nxt();

    // simultaneous IF + DM load: DM first, IF granted in DM response cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    dm_set(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    smp();
    chk("tie_dm_gnt", {bus.dm_gnt, bus.if_gnt}, 2'b10);
    chk("tie_stalls", {bus.stall_if, bus.stall_mem}, 2'b11);
    nxt(); smp();
    chk("tie_mem_addr", bus.mem_addr, 32'h100);
    chk("tie_mem_req", bus.mem_req, 1'b1);
    nxt(); nxt();
    bus.mem_rdata = 32'hCAFE0001;
    smp();
    chk("tie_dm_rvalid", bus.dm_rvalid, 1'b1);
    chk("tie_dm_rdata", bus.dm_rdata, 32'hCAFE0001);
    chk("tie_if_gnt", {bus.if_gnt, bus.dm_gnt, bus.if_rvalid}, 3'b100);
    nxt();
    bus.dm_req = 1'b0;
    smp();
    chk("tie_if_issue", {bus.mem_req, bus.mem_ctrl}, {1'b1, 3'b010});
    chk("tie_if_addr", bus.mem_addr, 32'h20);
    nxt(); nxt();
    bus.mem_rdata = 32'h12345678;
    smp();
    chk("tie_if_rvalid", {bus.if_rvalid, bus.dm_rvalid, bus.dm_gnt}, 3'b100);
    chk("tie_if_rdata", bus.if_rdata, 32'h12345678);
    nxt();
    bus.if_req = 1'b0;
    nxt();

    // starvation: IF loses 4 contested IDLE arbitrations, then wins the 5th
    for (int k = 0; k < 4; k++) begin
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      dm_set(1'b1, 1'b1, 3'b010, 32'h300 + 32'(k * 4), 32'(k));
      smp();
      chk($sformatf("stv_loss%0d", k), {bus.dm_gnt, bus.if_gnt}, 2'b10);
      nxt();
      bus.if_req = 1'b0;
      nxt(); nxt(); smp();
      chk($sformatf("stv_rsp%0d", k), {bus.dm_rvalid, bus.if_gnt}, 2'b10);
      nxt();
      bus.dm_req = 1'b0;
      nxt();
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    dm_set(1'b1, 1'b1, 3'b010, 32'h310, 32'h5);
    smp();
    chk("stv_if_forced", {bus.if_gnt, bus.dm_gnt}, 2'b10);
    nxt(); nxt(); nxt(); smp();
    chk("stv_if_rsp_dm_gnt", {bus.if_rvalid, bus.dm_gnt}, 2'b11);
    nxt();
    bus.if_req = 1'b0;
    nxt(); nxt(); smp();
    chk("stv_dm_done", bus.dm_rvalid, 1'b1);
    nxt();
    bus.dm_req = 1'b0;
    nxt();
    bus.if_req = 1'b1;
    dm_set(1'b1, 1'b1, 3'b010, 32'h320, 32'h6);
    smp();
    chk("stv_cleared", {bus.dm_gnt, bus.if_gnt}, 2'b10);
    nxt();
    bus.if_req = 1'b0;
    nxt(); nxt(); nxt();
    bus.dm_req = 1'b0;
    nxt();

    // store word
    dm_set(1'b1, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
    bus.mem_rdata = 32'h55555555;
    smp();
    chk("sw_gnt", bus.dm_gnt, 1'b1);
    nxt(); smp();
    chk("sw_mem", {bus.mem_req, bus.mem_we, bus.mem_ctrl}, {1'b1, 1'b1, 3'b010});
    chk("sw_addr", bus.mem_addr, 32'h200);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    nxt(); nxt(); smp();
    chk("sw_rvalid", {bus.dm_rvalid, bus.dm_err}, 2'b10);
    chk("sw_rdata", bus.dm_rdata, 32'h0);
    nxt();
    bus.dm_req = 1'b0;
    nxt();

    // reset while waiting on memory
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    nxt(); nxt();
    rst_n = 1'b0; bus.if_req = 1'b0;
    smp();
    chk("rstw_mem_req", bus.mem_req, 1'b0);
    chk("rstw_mem_addr", bus.mem_addr, 32'h0);
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk($sformatf("rstw_quiet%0d", c), {bus.if_rvalid, bus.dm_rvalid, bus.mem_req}, 3'b0);
      nxt();
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.mem_rdata = 32'h0000ABCD;
    smp();
    chk("rstw_new_gnt", bus.if_gnt, 1'b1);
    nxt(); nxt(); nxt(); smp();
    chk("rstw_new_rvalid", bus.if_rvalid, 1'b1);
    chk("rstw_new_rdata", bus.if_rdata, 32'h0000ABCD);
    nxt();
    bus.if_req = 1'b0;
    nxt();

    // misaligned LW
    dm_set(1'b1, 1'b0, 3'b010, 32'h202, 32'h0);
    bus.mem_rdata = 32'h77777777;
    smp();
    chk("mis_gnt", bus.dm_gnt, 1'b1);
    nxt(); smp();
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_req", bus.mem_req, 1'b0);
    chk("mis_err", {bus.dm_rvalid, bus.dm_err}, 2'b11);
    chk("mis_rdata", bus.dm_rdata, 32'h0);
    nxt();
    bus.dm_req = 1'b0;
    smp();
    chk("mis_done", {bus.dm_rvalid, bus.mem_req}, 2'b0);
`else
    chk("mis_req", bus.mem_req, 1'b1);
    chk("mis_addr", bus.mem_addr, 32'h202);
    chk("mis_no_rv", bus.dm_rvalid, 1'b0);
    nxt(); nxt(); smp();
    chk("mis_rvalid", {bus.dm_rvalid, bus.dm_err}, 2'b10);
    chk("mis_rdata", bus.dm_rdata, 32'h77777777);
    nxt();
    bus.dm_req = 1'b0;
`endif
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined RV32I core.
- Sequences each access: grant, issue, fixed-latency wait, response.
- Drives per-stage stall signals so the pipeline freezes while its access is outstanding.
- Forwards the load/store width code (DMCtrl encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU) unchanged to memory.

Parameters:
- MEM_LAT, 2, cycles from the mem_req cycle to the mem_rdata-valid cycle; legal range ≥1.
- STARVE_MAX, 4, consecutive arbitration losses by IF after which IF is forced to win; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_rvalid
- if_addr  in  32  fetch address; stable while if_req high
- if_gnt  out  1  one-cycle pulse: request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request; held high until dm_rvalid
- dm_we  in  1  1 = store
- dm_ctrl  in  3  DMCtrl width code
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_gnt  out  1  one-cycle pulse: request accepted
- dm_rvalid  out  1  one-cycle pulse: load data valid or store complete
- dm_rdata  out  32  load data; 0 for stores
- dm_err  out  1  misalignment error, qualified by dm_rvalid
- mem_req  out  1  memory access strobe, one cycle per access
- mem_we  out  1  registered copy of dm_we (0 for IF)
- mem_ctrl  out  3  registered width code (010 for IF)
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered store data
- mem_rdata  in  32  valid exactly MEM_LAT cycles after mem_req
- stall_if  out  1  if_req & ~if_rvalid
- stall_mem  out  1  dm_req & ~dm_rvalid

Behaviour:
- Clocking/reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE.
  - Starvation counter, latency counter and all mem_* registers = 0.
  - All gnt/rvalid/err pulses = 0.
- FSM states:
  - IDLE: arbitrate when any eligible request is present. The winner gets a gnt pulse; addr/we/ctrl/wdata are captured; next state ISSUE.
  - ISSUE: mem_req=1 for exactly one cycle; latency counter loaded with MEM_LAT-1; next state WAIT.
  - WAIT: counter decrements each cycle. At counter==0 (response cycle):
    - the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through; dm_rdata=0 for stores);
    - the same cycle re-arbitrates: go to ISSUE with gnt if an eligible request exists, else IDLE.
- Eligibility: in the response cycle, the requester being served is ineligible because its req is still high from the completing access. It may re-request from the next cycle.
- Priority:
  - DM wins ties by default (older instruction).
  - The starvation counter increments each time IF loses with if_req high, and clears when IF wins.
  - When the counter equals STARVE_MAX, IF wins the tie.
- Timing:
  - Latency from the grant cycle to rvalid = MEM_LAT+1 cycles.
  - Peak throughput = one access per MEM_LAT+1 cycles.
  - Only one outstanding access at any time.
- A requester that drops req before gnt is simply not served. Dropping req after gnt is illegal; the access still completes and rvalid still pulses.
- mem_* outputs hold their values outside ISSUE; only mem_req qualifies them.
- Reset mid-operation: immediate return to IDLE. An in-flight memory response is discarded and no rvalid is generated.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - On a DM grant, the address is checked: H/HU requires addr[0]==0; W requires addr[1:0]==00.
  - A misaligned access issues no mem_req. Instead, the next cycle pulses dm_rvalid=1, dm_err=1, dm_rdata=0, then the FSM returns to IDLE.
  - The starvation counter still updates normally.
- When undefined: dm_err is tied 0 and misaligned accesses go to memory unchanged.

Test Plan:
- MEM_LAT=2, lone if_req addr 0x0000_0010, mem_rdata=0x00A00093 -> if_gnt at cycle 0, mem_req at cycle 1 with mem_addr=0x10 and mem_ctrl=010, if_rvalid with if_rdata=0x00A00093 at cycle 3, stall_if high cycles 0–2.
- if_req and dm_req (load, addr 0x100) raised in the same cycle -> DM granted first; IF granted in DM's response cycle; if_rvalid exactly 3 cycles after dm_rvalid.
- dm_req held continuously with back-to-back stores plus if_req, STARVE_MAX=4 -> IF loses 4 arbitrations and wins the 5th; the counter then clears.
- Store SW addr 0x200, wdata 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, mem_ctrl=010; dm_rvalid with dm_rdata=0 two cycles later.
- rst_n asserted in WAIT -> mem_req=0 and FSM=IDLE immediately; no rvalid after release; a new request is served normally.
- MISALIGN_TRAP_EN defined, LW addr 0x202 -> no mem_req; dm_rvalid=1 and dm_err=1 the cycle after dm_gnt. With the macro undefined, mem_req is issued with mem_addr=0x202.
